imm_compress: RTL and testbench

IMM_COMPRESS -- requirements
Module: imm_compress

---
 rtl/imm_compress.sv | 143 ++++++++++++++
 tb/tb_imm_compress.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/imm_compress.sv
// rtl/imm_compress.sv - 16-bit immediate to 7-bit field packer with 2-entry output FIFO
//
// Purpose: packs a 16-bit immediate into a 7-bit field (signed or unsigned),
// flags whether the packing was exact, and buffers results in a 2-deep FIFO.
// Values that do not fit are saturated, and they are counted in a saturating
// error counter.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - upstream value present
//   in_ready   - block accepts a value this cycle
//   in_value   - 16-bit immediate
//   in_signed  - 1: signed 7-bit field, 0: unsigned 7-bit field
//   out_valid  - FIFO head holds an entry
//   out_ready  - downstream consumes the head this cycle
//   out_imm    - packed 7-bit field at the head
//   out_fit    - 1: exact, 0: saturated
//   err_count  - saturating count of accepted values that did not fit

module imm_compress #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_value,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_imm,
  output logic             out_fit,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  state_t     state;
  logic [6:0] mem_imm [2];
  logic       mem_fit [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       rdy_q;

  logic [6:0] enc_imm;
  logic       enc_fit;
  logic       push;
  logic       pop;

  // Combinational encoder. A signed fit needs bits 15:6 to be identical,
  // so that sign-extending bit 6 gives back the original value.
  always_comb begin
    enc_imm = in_value[6:0];
    enc_fit = 1'b1;
    if (in_signed) begin
      if (!((in_value[15:6] == 10'h000) || (in_value[15:6] == 10'h3FF))) begin
        enc_fit = 1'b0;
        enc_imm = in_value[15] ? 7'h40 : 7'h3F;
      end
    end else begin
      if (in_value[15:7] != 9'h000) begin
        enc_fit = 1'b0;
        enc_imm = 7'h7F;
      end
    end
  end

  // in_ready is the registered rdy_q, so it never depends on out_ready
  // within the same cycle. A FULL FIFO cannot pass a value through, even
  // when it is popping.
  assign push      = in_valid && rdy_q;
  assign pop       = (state != EMPTY) && out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = (state != EMPTY);
  assign out_imm   = mem_imm[rd_ptr];
  assign out_fit   = mem_fit[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rdy_q     <= 1'b0;
      err_count <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_imm[i] <= 7'h00;
        mem_fit[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= enc_imm;
        mem_fit[wr_ptr] <= enc_fit;
        wr_ptr          <= ~wr_ptr;
        if (!enc_fit && (err_count != ERR_MAX)) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      // A push and a pop together in ONE keep the count at 1. The read
      // pointer then moves onto the slot that was just written.
      case (state)
        EMPTY: begin
          rdy_q <= 1'b1;
          if (push) state <= ONE;
        end
        ONE: begin
          if (push && !pop) begin
            state <= FULL;
            rdy_q <= 1'b0;
          end else if (pop && !push) begin
            state <= EMPTY;
            rdy_q <= 1'b1;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state <= ONE;
            rdy_q <= 1'b1;
          end else begin
            rdy_q <= 1'b0;
          end
        end
        default: begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_compress.sv
// tb/tb_imm_compress.sv - directed self-checking bench for imm_compress

module tb_imm_compress;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_imm;
  logic        out_fit;
  logic [7:0]  err_count;

  int checks;
  int errors;

  imm_compress #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_fit   (out_fit),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle, so outputs are sampled away from the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic v, input logic [6:0] imm, input logic fit);
    chk({tag, "_valid"}, 16'(out_valid), 16'(v));
    chk({tag, "_imm"},   16'(out_imm),   16'(imm));
    chk({tag, "_fit"},   16'(out_fit),   16'(fit));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_value  = 16'h0000;
    in_signed = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    head("rst", 1'b0, 7'h00, 1'b0);
    chk("rst_err", 16'(err_count), 16'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_in_ready", 16'(in_ready), 16'd1);
    chk("post_rst_valid", 16'(out_valid), 16'd0);

    // Unsigned 0x0055 fits, with 1-cycle latency
    in_valid = 1'b1; in_value = 16'h0055; in_signed = 1'b0; out_ready = 1'b1;
    tick;
    head("u55", 1'b1, 7'h55, 1'b1);
    chk("u55_err", 16'(err_count), 16'd0);
    in_valid = 1'b0;
    tick;
    chk("u55_drained", 16'(out_valid), 16'd0);

    // Signed cases; each edge after the first both pushes and pops
    in_valid = 1'b1; in_value = 16'hFFC1; in_signed = 1'b1;
    tick;
    head("sFFC1", 1'b1, 7'h41, 1'b1);
    in_value = 16'h0040;
    tick;
    head("s0040", 1'b1, 7'h3F, 1'b0);
    chk("s0040_err", 16'(err_count), 16'd1);
    in_value = 16'h8000;
    tick;
    head("s8000", 1'b1, 7'h40, 1'b0);
    chk("s8000_err", 16'(err_count), 16'd2);
    in_valid = 1'b0;
    tick;
    chk("s_drained", 16'(out_valid), 16'd0);

    // Backpressure: fill to FULL, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_signed = 1'b0; in_value = 16'h0001;
    tick;
    chk("bp1_in_ready", 16'(in_ready), 16'd1);
    in_value = 16'h0002;
    tick;
    chk("bp2_in_ready", 16'(in_ready), 16'd0);
    in_value = 16'h0003;
    tick;
    chk("bp3_in_ready", 16'(in_ready), 16'd0);
    head("bp3_hold", 1'b1, 7'h01, 1'b1);
    out_ready = 1'b1;
    tick;
    head("bp_out1", 1'b1, 7'h02, 1'b1);
    chk("bp_ready_back", 16'(in_ready), 16'd1);
    tick;
    head("bp_out2", 1'b1, 7'h03, 1'b1);
    in_valid = 1'b0;
    tick;
    chk("bp_drained", 16'(out_valid), 16'd0);
    chk("bp_err", 16'(err_count), 16'd2);

    // ONE state with a simultaneous push of 0x0F and a pop
    out_ready = 1'b0; in_valid = 1'b1; in_value = 16'h0010;
    tick;
    head("one_pre", 1'b1, 7'h10, 1'b1);
    in_value = 16'h000F; out_ready = 1'b1;
    tick;
    head("one_swap", 1'b1, 7'h0F, 1'b1);
    chk("one_swap_ready", 16'(in_ready), 16'd1);
    in_valid = 1'b0;
    tick;
    chk("one_drained", 16'(out_valid), 16'd0);
    out_ready = 1'b1;
    in_value  = 16'hFFFF;
    tick;
    chk("empty_pop_ignored", 16'(out_valid), 16'd0);

    // Reset mid-operation with two entries buffered
    out_ready = 1'b0; in_valid = 1'b1; in_value = 16'h0011;
    tick;
    in_value = 16'h0200;
    tick;
    in_valid = 1'b0;
    chk("pre_rst_err", 16'(err_count), 16'd3);
    chk("pre_rst_full", 16'(in_ready), 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    head("async_rst", 1'b0, 7'h00, 1'b0);
    chk("async_rst_err", 16'(err_count), 16'd0);
    chk("async_rst_in_ready", 16'(in_ready), 16'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("rel_in_ready", 16'(in_ready), 16'd1);
    chk("rel_valid", 16'(out_valid), 16'd0);

    // The error counter saturates at 255 over 260 values that do not fit
    out_ready = 1'b1; in_valid = 1'b1; in_signed = 1'b0; in_value = 16'h0100;
    for (int i = 0; i < 260; i++) begin
      tick;
      chk("sat_imm", 16'(out_imm), 16'h007F);
      chk("sat_err", 16'(err_count), (i < 255) ? 16'(i + 1) : 16'd255);
    end
    in_valid = 1'b0;
    tick;
    chk("sat_final_err", 16'(err_count), 16'd255);
    chk("sat_drained", 16'(out_valid), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
